fp16_operand_decode: RTL and testbench

FP16_OPERAND_DECODE -- requirements
Module: fp16_operand_decode

---
 rtl/fp16_operand_decode_if.sv | 36 +++
 rtl/fp16_operand_decode.sv | 122 ++++++++++++
 tb/tb_fp16_operand_decode.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fp16_operand_decode_if.sv
// Operand-pair handshake bundle for the binary16 operand decoder.
// The slave view belongs to the decoder; the master view belongs to whoever drives it.
interface fp16_operand_decode_if;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] in_a;
   logic [15:0] in_b;
   logic        out_valid;
   logic        out_ready;
   logic        SIGN_A;
   logic        SIGN_B;
   logic [4:0]  IN_EXP_A_HALF;
   logic [4:0]  IN_EXP_B_HALF;
   logic [10:0] IN_MANT_A_HALF;
   logic [10:0] IN_MANT_B_HALF;
   logic [9:0]  MANTISSA_DECODE_A;
   logic [9:0]  MANTISSA_DECODE_B;
   logic [2:0]  cls_a;
   logic [2:0]  cls_b;

   modport slave (
      input  in_valid, in_a, in_b, out_ready,
      output in_ready, out_valid,
      output SIGN_A, SIGN_B, IN_EXP_A_HALF, IN_EXP_B_HALF,
      output IN_MANT_A_HALF, IN_MANT_B_HALF,
      output MANTISSA_DECODE_A, MANTISSA_DECODE_B, cls_a, cls_b
   );

   modport master (
      output in_valid, in_a, in_b, out_ready,
      input  in_ready, out_valid,
      input  SIGN_A, SIGN_B, IN_EXP_A_HALF, IN_EXP_B_HALF,
      input  IN_MANT_A_HALF, IN_MANT_B_HALF,
      input  MANTISSA_DECODE_A, MANTISSA_DECODE_B, cls_a, cls_b
   );
endinterface

// File: rtl/fp16_operand_decode.sv
// Splits a pair of binary16 operands into sign/exponent/significand/class fields,
// registered once, with a one-entry skid buffer so in_ready is a pure register.
module fp16_operand_decode #(
   parameter bit FTZ = 1'b0
) (
   input logic                   clk,
   input logic                   rst,
   fp16_operand_decode_if.slave  bus
);

   typedef enum logic [2:0] {
      CLS_ZERO = 3'd0,
      CLS_SUB  = 3'd1,
      CLS_NORM = 3'd2,
      CLS_INF  = 3'd3,
      CLS_QNAN = 3'd4,
      CLS_SNAN = 3'd5
   } cls_e;

   typedef struct packed {
      logic        sign;
      logic [4:0]  exp;
      logic [10:0] mant;
      logic [9:0]  frac;
      cls_e        cls;
   } dec_t;

   // Flushing the fraction of an exp-0 operand turns a subnormal into a signed zero.
   function automatic dec_t decode(input logic [15:0] x);
      dec_t       d;
      logic [4:0] e;
      logic [9:0] f;
      e = x[14:10];
      f = x[9:0];
      if (FTZ && (e == 5'd0)) f = 10'd0;
      d.sign = x[15];
      d.exp  = e;
      d.frac = f;
      d.mant = {(e != 5'd0), f};
      if (e == 5'd0)
         d.cls = (f == 10'd0) ? CLS_ZERO : CLS_SUB;
      else if (e == 5'd31)
         d.cls = (f == 10'd0) ? CLS_INF : (f[9] ? CLS_QNAN : CLS_SNAN);
      else
         d.cls = CLS_NORM;
      return d;
   endfunction

   dec_t out_a_q, out_b_q, skid_a_q, skid_b_q;
   dec_t out_a_d, out_b_d, skid_a_d, skid_b_d;
   dec_t dec_a, dec_b;
   logic out_valid_q, out_valid_d;
   logic skid_full_q, skid_full_d;
   logic in_ready_q;
   logic accept, xfer;

   // The skid entry is always older than any new pair, so it refills the output first.
   always_comb begin
      dec_a       = decode(bus.in_a);
      dec_b       = decode(bus.in_b);
      accept      = bus.in_valid && in_ready_q;
      xfer        = out_valid_q && bus.out_ready;
      out_a_d     = out_a_q;
      out_b_d     = out_b_q;
      skid_a_d    = skid_a_q;
      skid_b_d    = skid_b_q;
      out_valid_d = out_valid_q;
      skid_full_d = skid_full_q;
      if (!out_valid_q || xfer) begin
         if (skid_full_q) begin
            out_a_d     = skid_a_q;
            out_b_d     = skid_b_q;
            out_valid_d = 1'b1;
            skid_full_d = 1'b0;
         end else if (accept) begin
            out_a_d     = dec_a;
            out_b_d     = dec_b;
            out_valid_d = 1'b1;
         end else begin
            out_valid_d = 1'b0;
         end
      end else if (accept) begin
         skid_a_d    = dec_a;
         skid_b_d    = dec_b;
         skid_full_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_a_q     <= '0;
         out_b_q     <= '0;
         skid_a_q    <= '0;
         skid_b_q    <= '0;
         out_valid_q <= 1'b0;
         skid_full_q <= 1'b0;
         in_ready_q  <= 1'b0;
      end else begin
         out_a_q     <= out_a_d;
         out_b_q     <= out_b_d;
         skid_a_q    <= skid_a_d;
         skid_b_q    <= skid_b_d;
         out_valid_q <= out_valid_d;
         skid_full_q <= skid_full_d;
         in_ready_q  <= !skid_full_d;
      end
   end

   assign bus.in_ready          = in_ready_q;
   assign bus.out_valid         = out_valid_q;
   assign bus.SIGN_A            = out_a_q.sign;
   assign bus.SIGN_B            = out_b_q.sign;
   assign bus.IN_EXP_A_HALF     = out_a_q.exp;
   assign bus.IN_EXP_B_HALF     = out_b_q.exp;
   assign bus.IN_MANT_A_HALF    = out_a_q.mant;
   assign bus.IN_MANT_B_HALF    = out_b_q.mant;
   assign bus.MANTISSA_DECODE_A = out_a_q.frac;
   assign bus.MANTISSA_DECODE_B = out_b_q.frac;
   assign bus.cls_a             = out_a_q.cls;
   assign bus.cls_b             = out_b_q.cls;

endmodule

// File: tb/tb_fp16_operand_decode.sv
// Bench for fp16_operand_decode: two instances (FTZ off/on) share one stimulus stream
// and are compared each cycle against a queue-based occupancy model and a golden decode.
module tb_fp16_operand_decode;

   logic clk;
   logic rst;
   fp16_operand_decode_if ifa ();
   fp16_operand_decode_if ifb ();

   fp16_operand_decode #(.FTZ(1'b0)) dut_noftz (.clk(clk), .rst(rst), .bus(ifa));
   fp16_operand_decode #(.FTZ(1'b1)) dut_ftz   (.clk(clk), .rst(rst), .bus(ifb));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   int          n_accepted = 0;
   bit          model_on = 1'b0;
   bit          exp_in_ready = 1'b0;
   logic [31:0] pair_q [$];

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b, input logic r);
      ifa.in_valid = v;  ifb.in_valid = v;
      ifa.in_a = a;      ifb.in_a = a;
      ifa.in_b = b;      ifb.in_b = b;
      ifa.out_ready = r; ifb.out_ready = r;
   endtask

   // Golden decode from the field definitions: {sign, exp, significand, fraction, class}
   function automatic logic [29:0] golden(input logic [15:0] x, input bit ftz);
      int unsigned e, f, m, c;
      logic [29:0] r;
      e = (x / 1024) % 32;
      f = x % 1024;
      if (ftz && e == 0) f = 0;
      if (e == 0)       c = (f == 0) ? 0 : 1;
      else if (e == 31) c = (f == 0) ? 3 : ((f >= 512) ? 4 : 5);
      else              c = 2;
      m = (e != 0) ? 1024 + f : f;
      r = {x[15], 5'(e), 11'(m), 10'(f), 3'(c)};
      return r;
   endfunction

   function automatic logic [15:0] randOperand();
      logic [15:0] x;
      x = 16'($urandom);
      case ($urandom_range(0, 5))
         0: x[14:10] = 5'd0;
         1: x[14:10] = 5'd31;
         2: x[9:0]   = 10'd0;
         3: begin x[14:10] = 5'd0; x[9:0] = 10'd0; end
         default: ;
      endcase
      return x;
   endfunction

   // Occupancy model: the block holds 0..2 pairs; it accepts unless it holds 2.
   always @(posedge clk) begin
      bit acc, xf;
      if (rst) begin
         pair_q.delete();
         exp_in_ready = 1'b0;
      end else begin
         acc = ifa.in_valid && exp_in_ready;
         xf  = (pair_q.size() > 0) && ifa.out_ready;
         if (xf) void'(pair_q.pop_front());
         if (acc) begin
            pair_q.push_back({ifa.in_a, ifa.in_b});
            n_accepted++;
         end
         exp_in_ready = (pair_q.size() < 2);
      end
   end

   always @(negedge clk) begin
      if (model_on) begin
         checkOutput("out_valid_noftz", 32'(ifa.out_valid), 32'(pair_q.size() > 0));
         checkOutput("out_valid_ftz", 32'(ifb.out_valid), 32'(pair_q.size() > 0));
         checkOutput("in_ready_noftz", 32'(ifa.in_ready), 32'(exp_in_ready));
         checkOutput("in_ready_ftz", 32'(ifb.in_ready), 32'(exp_in_ready));
         if (pair_q.size() > 0) begin
            checkOutput("dec_a_noftz", 32'({ifa.SIGN_A, ifa.IN_EXP_A_HALF, ifa.IN_MANT_A_HALF,
                        ifa.MANTISSA_DECODE_A, ifa.cls_a}), 32'(golden(pair_q[0][31:16], 1'b0)));
            checkOutput("dec_b_noftz", 32'({ifa.SIGN_B, ifa.IN_EXP_B_HALF, ifa.IN_MANT_B_HALF,
                        ifa.MANTISSA_DECODE_B, ifa.cls_b}), 32'(golden(pair_q[0][15:0], 1'b0)));
            checkOutput("dec_a_ftz", 32'({ifb.SIGN_A, ifb.IN_EXP_A_HALF, ifb.IN_MANT_A_HALF,
                        ifb.MANTISSA_DECODE_A, ifb.cls_a}), 32'(golden(pair_q[0][31:16], 1'b1)));
            checkOutput("dec_b_ftz", 32'({ifb.SIGN_B, ifb.IN_EXP_B_HALF, ifb.IN_MANT_B_HALF,
                        ifb.MANTISSA_DECODE_B, ifb.cls_b}), 32'(golden(pair_q[0][15:0], 1'b1)));
         end
      end
   end

   task automatic sendPair(input logic [15:0] a, input logic [15:0] b);
      @(posedge clk); #1 applyStimulus(1'b1, a, b, 1'b1);
      @(posedge clk); #1 applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
   endtask

   task automatic fillBoth();
      @(posedge clk); #1 applyStimulus(1'b1, 16'h3C00, 16'h4000, 1'b0);
      @(posedge clk); #1 applyStimulus(1'b1, 16'h4500, 16'hB800, 1'b0);
      @(posedge clk); #1 applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      @(negedge clk);
   endtask

   initial begin
      int cycles;
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      model_on = 1'b1;
      @(negedge clk);
      checkOutput("reset_out_valid", 32'(ifa.out_valid), 32'd0);
      checkOutput("reset_in_ready", 32'(ifa.in_ready), 32'd0);
      checkOutput("reset_cls_a", 32'(ifa.cls_a), 32'd0);
      checkOutput("reset_mant_a", 32'(ifa.IN_MANT_A_HALF), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      @(posedge clk); @(negedge clk);
      checkOutput("in_ready_after_reset", 32'(ifa.in_ready), 32'd1);

      sendPair(16'h3C00, 16'hC000);
      checkOutput("normal_sign_a", 32'(ifa.SIGN_A), 32'd0);
      checkOutput("normal_exp_a", 32'(ifa.IN_EXP_A_HALF), 32'd15);
      checkOutput("normal_mant_a", 32'(ifa.IN_MANT_A_HALF), 32'h400);
      checkOutput("normal_cls_a", 32'(ifa.cls_a), 32'd2);
      checkOutput("normal_sign_b", 32'(ifa.SIGN_B), 32'd1);
      checkOutput("normal_exp_b", 32'(ifa.IN_EXP_B_HALF), 32'd16);
      checkOutput("normal_mant_b", 32'(ifa.IN_MANT_B_HALF), 32'h400);
      checkOutput("normal_frac_b", 32'(ifa.MANTISSA_DECODE_B), 32'd0);

      sendPair(16'h7C00, 16'h7E01);
      checkOutput("inf_cls_a", 32'(ifa.cls_a), 32'd3);
      checkOutput("qnan_cls_b", 32'(ifa.cls_b), 32'd4);
      sendPair(16'h7C01, 16'h8000);
      checkOutput("snan_cls_a", 32'(ifa.cls_a), 32'd5);
      checkOutput("negzero_sign_b", 32'(ifa.SIGN_B), 32'd1);
      checkOutput("negzero_cls_b", 32'(ifa.cls_b), 32'd0);
      checkOutput("negzero_mant_b", 32'(ifa.IN_MANT_B_HALF), 32'd0);

      sendPair(16'h0001, 16'h8001);
      checkOutput("sub_noftz_mant_a", 32'(ifa.IN_MANT_A_HALF), 32'h001);
      checkOutput("sub_noftz_cls_a", 32'(ifa.cls_a), 32'd1);
      checkOutput("sub_ftz_mant_a", 32'(ifb.IN_MANT_A_HALF), 32'd0);
      checkOutput("sub_ftz_frac_a", 32'(ifb.MANTISSA_DECODE_A), 32'd0);
      checkOutput("sub_ftz_cls_a", 32'(ifb.cls_a), 32'd0);
      checkOutput("sub_ftz_sign_b", 32'(ifb.SIGN_B), 32'd1);

      fillBoth();
      checkOutput("bp_in_ready_low", 32'(ifa.in_ready), 32'd0);
      checkOutput("bp_p1_exp_a", 32'(ifa.IN_EXP_A_HALF), 32'd15);
      @(negedge clk);
      checkOutput("bp_p1_held", 32'(ifa.IN_EXP_B_HALF), 32'd16);
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
      checkOutput("bp_p2_exp_a", 32'(ifa.IN_EXP_A_HALF), 32'd17);
      checkOutput("bp_p2_frac_a", 32'(ifa.MANTISSA_DECODE_A), 32'h100);
      checkOutput("bp_p2_sign_b", 32'(ifa.SIGN_B), 32'd1);
      checkOutput("bp_in_ready_back", 32'(ifa.in_ready), 32'd1);
      @(negedge clk);
      checkOutput("bp_drained", 32'(ifa.out_valid), 32'd0);

      fillBoth();
      checkOutput("rst_full_in_ready", 32'(ifa.in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_mid_out_valid", 32'(ifa.out_valid), 32'd0);
      checkOutput("rst_mid_in_ready", 32'(ifa.in_ready), 32'd0);
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      @(negedge clk);
      checkOutput("rst_mid_ready_back", 32'(ifa.in_ready), 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("rst_mid_no_stale", 32'(ifa.out_valid), 32'd0);

      n_accepted = 0;
      cycles = 0;
      while (n_accepted < 10000 && cycles < 60000) begin
         @(posedge clk);
         #1 applyStimulus(($urandom_range(0, 9) < 7), randOperand(), randOperand(),
                          ($urandom_range(0, 9) < 6));
         cycles++;
      end
      #1 applyStimulus(1'b0, 16'h0, 16'h0, 1'b1);
      checkOutput("random_pairs_accepted", 32'(n_accepted >= 10000), 32'd1);
      repeat (5) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #5ms;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
